gate_response_checker: RTL and testbench

Synthesizable response-side companion to our gate stimulus benches. It sweeps every input combination of a combinational gate under test and waits a settle interval after each. It then samples the gate output, compares it against a parameterised truth table, and reports per-vector failures, an error count and pass/fail. It sits beside the gate under test on the lab board and replaces manual waveform inspection.

---
 rtl/gate_chk_pkg.sv | 27 ++
 rtl/gate_chk_timer.sv | 28 ++
 rtl/gate_response_checker.sv | 129 ++++++++++++
 tb/tb_gate_response_checker.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate response checker.
// Optional first-failure capture is enabled with GATE_CHK_FIRST_FAIL_EN.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } chk_state_t;

    // Common 2-input truth tables, bit i = expected output for stim == i
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NOR2  = 4'b0001;

    // Settle timer width covers the full 1..255 settle range
    localparam int TMR_W = 8;

    // Number of input vectors swept for an n-input gate
    function automatic int num_vec(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/gate_chk_timer.sv
// Loadable down-counter used for the per-vector settle interval.
module gate_chk_timer
    import gate_chk_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [TMR_W-1:0] count;

    // Load has priority; counting stops at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - TMR_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gate_response_checker.sv
// Sweeps all input vectors of a combinational gate, waits a settle interval
// on each, samples the gate output and compares it with a truth table.
// Define GATE_CHK_FIRST_FAIL_EN to add first_fail / first_fail_vld outputs.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int                N_IN   = 2,
    parameter logic [2**N_IN-1:0] TRUTH = 4'b0111,
    parameter int                SETTLE = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [N_IN-1:0]     stim,
    input  logic                dut_x,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_IN:0]       err_count,
`ifdef GATE_CHK_FIRST_FAIL_EN
    output logic [N_IN-1:0]     first_fail,
    output logic                first_fail_vld,
`endif
    output logic [2**N_IN-1:0]  fail_vec
);

    localparam int NV         = num_vec(N_IN);
    // A settle of 0 behaves like 1
    localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam logic [TMR_W-1:0] RELOAD = TMR_W'(SETTLE_EFF - 1);

    chk_state_t state, nxt;
    logic       load, en, zero;
    logic       accept, last_vec, mism;

    assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_vec = (stim == N_IN'(NV - 1));
    assign mism     = (state == S_SAMPLE) && (dut_x != TRUTH[stim]);

    gate_chk_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (RELOAD),
        .en       (en),
        .zero     (zero)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // Next-state and timer control
    always_comb begin
        nxt  = state;
        load = 1'b0;
        en   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    nxt  = S_SETTLE;
                    load = 1'b1;
                end
            end
            S_SETTLE: begin
                en = 1'b1;
                if (zero) nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (last_vec) begin
                    nxt = S_DONE;
                end else begin
                    nxt  = S_SETTLE;
                    load = 1'b1;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Sweep datapath: vector pointer, status flags and error record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else if (accept) begin
            stim      <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else if (state == S_SAMPLE) begin
            if (mism) begin
                err_count      <= err_count + (N_IN+1)'(1);
                fail_vec[stim] <= 1'b1;
            end
            if (last_vec) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                stim <= stim + N_IN'(1);
            end
        end
    end

`ifdef GATE_CHK_FIRST_FAIL_EN
    // Capture the first mismatching vector of a sweep only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (accept) begin
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (mism && !first_fail_vld) begin
            first_fail     <= stim;
            first_fail_vld <= 1'b1;
        end
    end
`endif

    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker with an arithmetic reference model.
// Honours GATE_CHK_FIRST_FAIL_EN when defined.
module tb_gate_response_checker;

    localparam int S   = 10;
    localparam int LAT = 4 * (S + 1);

    logic       clk = 1'b0;
    logic       rst_n, start, start2;
    logic [1:0] stim, stim2;
    logic       dut_x, dut_x2;
    logic       busy, done, pass, busy2, done2, pass2;
    logic [2:0] err_count, err_count2;
    logic [3:0] fail_vec, fail_vec2;
`ifdef GATE_CHK_FIRST_FAIL_EN
    logic [1:0] first_fail, first_fail2;
    logic       first_fail_vld, first_fail_vld2;
`endif

    int   mode;
    logic glitch;
    logic [3:0] tt = 4'b0111;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // mode 0: NAND, 1: AND, 2: stuck-at-1
    function automatic logic gate_f(input int md, input logic [1:0] v);
        case (md)
            1:       return v[1] & v[0];
            2:       return 1'b1;
            default: return ~(v[1] & v[0]);
        endcase
    endfunction

    function automatic logic exp_fail(input int md, input logic [1:0] v);
        return gate_f(md, v) != tt[v];
    endfunction

    assign dut_x  = gate_f(mode, stim) ^ glitch;
    assign dut_x2 = ~(stim2[1] & stim2[0]);

    gate_response_checker #(.N_IN(2), .TRUTH(4'b0111), .SETTLE(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .dut_x(dut_x),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
`ifdef GATE_CHK_FIRST_FAIL_EN
        .first_fail(first_fail), .first_fail_vld(first_fail_vld),
`endif
        .fail_vec(fail_vec)
    );

    gate_response_checker #(.N_IN(2), .TRUTH(4'b0111), .SETTLE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stim(stim2), .dut_x(dut_x2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
`ifdef GATE_CHK_FIRST_FAIL_EN
        .first_fail(first_fail2), .first_fail_vld(first_fail_vld2),
`endif
        .fail_vec(fail_vec2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a sweep is just "edges elapsed since accepted start"
    bit m_run;
    int m_j;
    int m_mode;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0;
            m_j   <= 0;
        end else if (start && (!m_run || m_j >= LAT)) begin
            m_run  <= 1'b1;
            m_j    <= 0;
            m_mode <= mode;
        end else if (m_run && m_j < LAT) begin
            m_j <= m_j + 1;
        end
    end

    // Every cycle: vectors sampled so far = elapsed / (S+1)
    always @(negedge clk) begin
        int nv, sv, e, ff;
        bit bz, dn, fvld;
        logic [3:0] fv;
        if (!m_run) begin
            nv = 0; sv = 0; bz = 0; dn = 0;
        end else begin
            nv = m_j / (S + 1);
            if (nv > 4) nv = 4;
            sv = (nv > 3) ? 3 : nv;
            bz = (m_j < LAT);
            dn = !bz;
        end
        e = 0; fv = '0; ff = 0; fvld = 0;
        for (int v = 0; v < nv; v++) begin
            if (exp_fail(m_mode, 2'(v))) begin
                e++;
                fv[v] = 1'b1;
                if (!fvld) begin ff = v; fvld = 1; end
            end
        end
        chk("m_stim", int'(stim), sv);
        chk("m_busy", int'(busy), int'(bz));
        chk("m_done", int'(done), int'(dn));
        chk("m_err", int'(err_count), e);
        chk("m_fail_vec", int'(fail_vec), int'(fv));
        chk("m_pass", int'(pass), int'(dn && e == 0));
`ifdef GATE_CHK_FIRST_FAIL_EN
        chk("m_ff_vld", int'(first_fail_vld), int'(fvld));
        chk("m_ff", int'(first_fail), ff);
`endif
    end

    // Counts edges from the accepting edge until done is seen
    task automatic wait_done(input int restart_at, input int glitch_at, output int lat);
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            start  = (lat == restart_at);
            glitch = (lat >= glitch_at) && (lat < glitch_at + 3);
        end
        start  = 1'b0;
        glitch = 1'b0;
        if (lat >= 200) chk("timeout", 0, 1);
    endtask

    task automatic run_sweep(input int md, input int restart_at, input int glitch_at,
                             output int lat);
        mode  = md;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(restart_at, glitch_at, lat);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 0; glitch = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_stim", int'(stim), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: correct NAND
        run_sweep(0, -1, -10, lat);
        chk("t1_lat", lat, 44);
        chk("t1_pass", int'(pass), 1);
        chk("t1_err", int'(err_count), 0);
        chk("t1_fv", int'(fail_vec), 0);

        // 2: AND in place of NAND
        run_sweep(1, -1, -10, lat);
        chk("t2_err", int'(err_count), 4);
        chk("t2_fv", int'(fail_vec), 15);
        chk("t2_pass", int'(pass), 0);
`ifdef GATE_CHK_FIRST_FAIL_EN
        chk("t2_ff", int'(first_fail), 0);
        chk("t2_ffv", int'(first_fail_vld), 1);
`endif

        // 3: stuck-at-1
        run_sweep(2, -1, -10, lat);
        chk("t3_err", int'(err_count), 1);
        chk("t3_fv", int'(fail_vec), 8);
        chk("t3_pass", int'(pass), 0);
`ifdef GATE_CHK_FIRST_FAIL_EN
        chk("t3_ff", int'(first_fail), 3);
`endif

        // 4: start while busy ignored, start in DONE restarts
        run_sweep(1, 20, -10, lat);
        chk("t4_lat", lat, 44);
        chk("t4_err", int'(err_count), 4);
        mode  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_done", int'(done), 0);
        chk("t4_err0", int'(err_count), 0);
        chk("t4_busy", int'(busy), 1);
        wait_done(-1, -10, lat);
        chk("t4_lat2", lat, 44);

        // 5: async reset during vector 2 settle
        mode  = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_stim", int'(stim), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_err", int'(err_count), 0);
        chk("t5_fv", int'(fail_vec), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_idle_busy", int'(busy), 0);
        chk("t5_idle_done", int'(done), 0);

        // 6: glitch early in settle of vector 1 is ignored
        run_sweep(0, -1, 12, lat);
        chk("t6_lat", lat, 44);
        chk("t6_pass", int'(pass), 1);

        // 6b: SETTLE=1 sweep takes 8 cycles
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("t6_lat_s1", lat, 8);
        chk("t6_pass_s1", int'(pass2), 1);
        chk("t6_err_s1", int'(err_count2), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
